cpu_core_mc: RTL and testbench

//  Parametrised multi-cycle CPU core. Successor to the fixed 8-bit single-cycle CPU top level.

---
 rtl/cpu_core_mc.sv | 221 ++++++++++++++++++++++
 tb/tb_cpu_core_mc.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_core_mc.sv
// Multi-cycle CPU core: FETCH/DECODE/EXEC sequencing over an external
// synchronous instruction ROM, with a registered flags word, conditional
// branches, HALT and a valid/ready OUT port.
module cpu_core_mc #(
  parameter  int DATA_W   = 8,
  parameter  int PC_W     = 8,
  parameter  int NUM_REGS = 8,
  localparam int RA_W     = $clog2(NUM_REGS),
  localparam int INSTR_W  = 4 + 2*RA_W + DATA_W
) (
  input  logic               clk,
  input  logic               reset,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [PC_W-1:0]    pc_out,
  output logic [3:0]         flags,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               halted
);

  localparam int MSB = DATA_W - 1;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_OUTW,
    S_HALT
  } state_e;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_XOR  = 4'h4,
    OP_SHL  = 4'h5,
    OP_SHR  = 4'h6,
    OP_MOV  = 4'h7,
    OP_LDI  = 4'h8,
    OP_ADDI = 4'h9,
    OP_JMP  = 4'hA,
    OP_JZ   = 4'hB,
    OP_JC   = 4'hC,
    OP_NOP  = 4'hD,
    OP_OUT  = 4'hE,
    OP_HALT = 4'hF
  } op_e;

  state_e              r_state;
  state_e              w_state_next;
  logic [PC_W-1:0]     r_pc;
  logic [PC_W-1:0]     r_imem_addr;
  logic [INSTR_W-1:0]  r_ir;
  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [3:0]          r_flags;
  logic [DATA_W-1:0]   r_out_data;
  logic                r_out_valid;
  logic                r_halted;

  op_e                 w_op;
  logic [RA_W-1:0]     w_rd;
  logic [RA_W-1:0]     w_rs;
  logic [DATA_W-1:0]   w_imm;
  logic [DATA_W-1:0]   w_a;
  logic [DATA_W-1:0]   w_b;
  logic [DATA_W-1:0]   w_addend;
  logic [DATA_W:0]     w_sum;
  logic [DATA_W-1:0]   w_diff;
  logic [DATA_W-1:0]   w_res;
  logic                w_c;
  logic                w_v;
  logic                w_wr;
  logic                w_setf;
  logic [3:0]          w_flags_next;
  logic                w_taken;
  logic [PC_W-1:0]     w_pc_next;

  assign w_op  = op_e'(r_ir[INSTR_W-1 -: 4]);
  assign w_rd  = r_ir[INSTR_W-5 -: RA_W];
  assign w_rs  = r_ir[INSTR_W-5-RA_W -: RA_W];
  assign w_imm = r_ir[DATA_W-1:0];
  assign w_a   = r_regs[w_rd];
  assign w_b   = r_regs[w_rs];

  assign imem_addr = r_imem_addr;
  assign pc_out    = r_pc;
  assign flags     = r_flags;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign halted    = r_halted;

  // ALU: result, writeback enable and flag update for the instruction in IR
  always_comb begin
    w_res    = '0;
    w_c      = r_flags[1];
    w_v      = r_flags[2];
    w_wr     = 1'b0;
    w_setf   = 1'b0;
    w_addend = (w_op == OP_ADDI) ? w_imm : w_b;
    w_sum    = {1'b0, w_a} + {1'b0, w_addend};
    w_diff   = w_a - w_b;
    case (w_op)
      OP_ADD, OP_ADDI: begin
        w_res  = w_sum[MSB:0];
        w_c    = w_sum[DATA_W];
        w_v    = (w_a[MSB] == w_addend[MSB]) && (w_sum[MSB] != w_a[MSB]);
        w_wr   = 1'b1;
        w_setf = 1'b1;
      end
      OP_SUB: begin
        w_res  = w_diff;
        w_c    = (w_a < w_b);
        w_v    = (w_a[MSB] != w_b[MSB]) && (w_diff[MSB] != w_a[MSB]);
        w_wr   = 1'b1;
        w_setf = 1'b1;
      end
      OP_AND, OP_OR, OP_XOR: begin
        w_res  = (w_op == OP_AND) ? (w_a & w_b) :
                 (w_op == OP_OR)  ? (w_a | w_b) : (w_a ^ w_b);
        w_c    = 1'b0;
        w_v    = 1'b0;
        w_wr   = 1'b1;
        w_setf = 1'b1;
      end
      OP_SHL: begin
        w_res  = w_a << 1;
        w_c    = w_a[MSB];
        w_v    = 1'b0;
        w_wr   = 1'b1;
        w_setf = 1'b1;
      end
      OP_SHR: begin
        w_res  = w_a >> 1;
        w_c    = w_a[0];
        w_v    = 1'b0;
        w_wr   = 1'b1;
        w_setf = 1'b1;
      end
      OP_MOV: begin
        w_res = w_b;
        w_wr  = 1'b1;
      end
      OP_LDI: begin
        w_res = w_imm;
        w_wr  = 1'b1;
      end
      default: ;
    endcase
    w_flags_next = {w_res[MSB], w_v, w_c, (w_res == '0)};
  end

  // Branch resolution against the flags left by the previous instruction
  always_comb begin
    w_taken = 1'b0;
    case (w_op)
      OP_JMP:  w_taken = 1'b1;
      OP_JZ:   w_taken = r_flags[0];
      OP_JC:   w_taken = r_flags[1];
      default: w_taken = 1'b0;
    endcase
    w_pc_next = w_taken ? w_imm[PC_W-1:0] : r_pc + PC_W'(1);
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_state_next;
  end

  // FSM next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_FETCH:  w_state_next = S_DECODE;
      S_DECODE: w_state_next = S_EXEC;
      S_EXEC: begin
        if (w_op == OP_OUT)       w_state_next = S_OUTW;
        else if (w_op == OP_HALT) w_state_next = S_HALT;
        else                      w_state_next = S_FETCH;
      end
      S_OUTW:   if (out_ready) w_state_next = S_FETCH;
      S_HALT:   w_state_next = S_HALT;
      default:  w_state_next = S_FETCH;
    endcase
  end

  // Datapath registers: fetch address, IR, register file, flags, PC, OUT port
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc        <= '0;
      r_imem_addr <= '0;
      r_ir        <= '0;
      r_flags     <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_halted    <= 1'b0;
      for (int unsigned i = 0; i < NUM_REGS; i++) r_regs[i[RA_W-1:0]] <= '0;
    end else begin
      case (r_state)
        S_FETCH:  r_imem_addr <= r_pc;
        S_DECODE: r_ir <= imem_data;
        S_EXEC: begin
          r_pc <= w_pc_next;
          if (w_wr)   r_regs[w_rd] <= w_res;
          if (w_setf) r_flags <= w_flags_next;
          if (w_op == OP_OUT) begin
            r_out_data  <= w_a;
            r_out_valid <= 1'b1;
          end
          if (w_op == OP_HALT) r_halted <= 1'b1;
        end
        S_OUTW:   if (out_ready) r_out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_core_mc.sv
// Directed bench for cpu_core_mc: an 8-bit default instance and a
// DATA_W=16 / NUM_REGS=16 instance, each fed from a bench-side ROM.
module tb_cpu_core_mc;

  localparam logic [3:0] ADD = 4'h0, SUB = 4'h1, XORO = 4'h4, SHL = 4'h5,
                         SHR = 4'h6, LDI = 4'h8, ADDI = 4'h9, JMP = 4'hA,
                         JZ = 4'hB, JC = 4'hC, NOP = 4'hD, OUT = 4'hE, HLT = 4'hF;

  logic        clk = 1'b0;
  logic        reset;
  logic        out_ready;
  logic        out_ready2;

  logic [7:0]  imem_addr, pc_out, out_data;
  logic [17:0] imem_data;
  logic [3:0]  flags;
  logic        out_valid, halted;

  logic [7:0]  imem_addr2, pc_out2;
  logic [27:0] imem_data2;
  logic [15:0] out_data2;
  logic [3:0]  flags2;
  logic        out_valid2, halted2;

  logic [17:0] rom  [256];
  logic [27:0] rom2 [256];

  int n_checks = 0;
  int n_pass   = 0;
  int xfers    = 0;
  int both_hi  = 0;

  always #5 clk = ~clk;

  assign imem_data  = rom[imem_addr];
  assign imem_data2 = rom2[imem_addr2];

  cpu_core_mc #(.DATA_W(8), .PC_W(8), .NUM_REGS(8)) u_dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
    .pc_out(pc_out), .flags(flags), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .halted(halted)
  );

  cpu_core_mc #(.DATA_W(16), .PC_W(8), .NUM_REGS(16)) u_dut16 (
    .clk(clk), .reset(reset), .imem_addr(imem_addr2), .imem_data(imem_data2),
    .pc_out(pc_out2), .flags(flags2), .out_data(out_data2), .out_valid(out_valid2),
    .out_ready(out_ready2), .halted(halted2)
  );

  always @(posedge clk) if (!reset && out_valid && out_ready) xfers++;
  always @(negedge clk) if (halted && out_valid) both_hi++;

  function automatic logic [17:0] enc(input logic [3:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs, input logic [7:0] imm);
    return {op, rd, rs, imm};
  endfunction

  function automatic logic [27:0] enc16(input logic [3:0] op, input logic [3:0] rd,
                                        input logic [3:0] rs, input logic [15:0] imm);
    return {op, rd, rs, imm};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) begin
      rom[i]  = enc(NOP, 3'd0, 3'd0, 8'h00);
      rom2[i] = enc16(NOP, 4'd0, 4'd0, 16'h0000);
    end
  endtask

  initial begin
    int held;
    int stuck;
    int x0;
    reset      = 1'b1;
    out_ready  = 1'b1;
    out_ready2 = 1'b1;
    clear_rom();
    @(negedge clk);

    // reset state
    check("rst_pc",        32'(pc_out),    32'h0);
    check("rst_imem_addr", 32'(imem_addr), 32'h0);
    check("rst_flags",     32'(flags),     32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_data",  32'(out_data),  32'h0);
    check("rst_halted",    32'(halted),    32'h0);

    // LDI/LDI/ADD with carry, then OUT and HALT
    clear_rom();
    rom[0] = enc(LDI, 3'd1, 3'd0, 8'd200);
    rom[1] = enc(LDI, 3'd2, 3'd0, 8'd100);
    rom[2] = enc(ADD, 3'd1, 3'd2, 8'd0);
    rom[3] = enc(OUT, 3'd1, 3'd0, 8'd0);
    rom[4] = enc(HLT, 3'd0, 3'd0, 8'd0);
    do_reset();
    cyc(9);
    check("add_pc",    32'(pc_out), 32'h3);
    check("add_flags", 32'(flags),  32'b0010);
    cyc(3);
    check("add_out_valid", 32'(out_valid), 32'h1);
    check("add_out_data",  32'(out_data),  32'd44);
    cyc(1);
    check("add_out_done", 32'(out_valid), 32'h0);
    cyc(3);
    check("add_halt_pc", 32'({halted, pc_out}), 32'h105);

    // SUB to zero then JZ taken
    clear_rom();
    rom[0]    = enc(LDI, 3'd1, 3'd0, 8'd5);
    rom[1]    = enc(SUB, 3'd1, 3'd1, 8'd0);
    rom[2]    = enc(JZ,  3'd0, 3'd0, 8'h10);
    rom[8'h10] = enc(HLT, 3'd0, 3'd0, 8'd0);
    do_reset();
    cyc(6);
    check("jz_t_flags", 32'(flags), 32'b0001);
    cyc(3);
    check("jz_t_pc", 32'(pc_out), 32'h10);

    // SUB leaving nonzero then JZ not taken
    rom[1] = enc(SUB, 3'd1, 3'd2, 8'd0);
    do_reset();
    cyc(6);
    check("jz_n_flags", 32'(flags), 32'b0000);
    cyc(3);
    check("jz_n_pc", 32'(pc_out), 32'h3);

    // SHL carry out, JC taken, SHR, XOR to zero
    clear_rom();
    rom[0]     = enc(LDI,  3'd3, 3'd0, 8'h81);
    rom[1]     = enc(SHL,  3'd3, 3'd0, 8'd0);
    rom[2]     = enc(JC,   3'd0, 3'd0, 8'h20);
    rom[8'h20] = enc(SHR,  3'd3, 3'd0, 8'd0);
    rom[8'h21] = enc(XORO, 3'd3, 3'd3, 8'd0);
    rom[8'h22] = enc(HLT,  3'd0, 3'd0, 8'd0);
    do_reset();
    cyc(6);
    check("shl_flags", 32'(flags), 32'b0010);
    cyc(3);
    check("jc_pc", 32'(pc_out), 32'h20);
    cyc(3);
    check("shr_flags", 32'(flags), 32'b0000);
    cyc(3);
    check("xor_flags", 32'(flags), 32'b0001);
    check("xor_pc",    32'(pc_out), 32'h22);

    // OUT with back-pressure: ready low for 4 cycles
    clear_rom();
    rom[0] = enc(LDI, 3'd1, 3'd0, 8'h5A);
    rom[1] = enc(OUT, 3'd1, 3'd0, 8'd0);
    rom[2] = enc(HLT, 3'd0, 3'd0, 8'd0);
    out_ready = 1'b0;
    do_reset();
    x0 = xfers;
    cyc(6);
    held = 0;
    for (int k = 0; k < 5; k++) begin
      if (out_valid === 1'b1 && out_data === 8'h5A) held++;
      if (k == 4) out_ready = 1'b1;
      cyc(1);
    end
    check("bp_held_cycles", 32'(held), 32'd5);
    check("bp_valid_drop",  32'(out_valid), 32'h0);
    check("bp_transfers",   32'(xfers - x0), 32'd1);

    // reset while waiting in OUTW
    clear_rom();
    rom[0] = enc(LDI,  3'd1, 3'd0, 8'h5A);
    rom[1] = enc(ADDI, 3'd1, 3'd0, 8'hFF);
    rom[2] = enc(OUT,  3'd1, 3'd0, 8'd0);
    out_ready = 1'b0;
    do_reset();
    cyc(6);
    check("addi_flags", 32'(flags), 32'b0010);
    cyc(3);
    check("outw_data", 32'({out_valid, out_data}), 32'h159);
    cyc(1);
    reset = 1'b1;
    cyc(1);
    check("mid_rst_valid",  32'(out_valid), 32'h0);
    check("mid_rst_pc",     32'(pc_out),    32'h0);
    check("mid_rst_halted", 32'(halted),    32'h0);
    check("mid_rst_flags",  32'(flags),     32'h0);
    check("mid_rst_data",   32'(out_data),  32'h0);
    reset = 1'b0;
    out_ready = 1'b1;

    // PC wrap from 0xFF to 0x00, then HALT freeze
    clear_rom();
    rom[0]     = enc(JMP, 3'd0, 3'd0, 8'hFF);
    rom[8'hFF] = enc(NOP, 3'd0, 3'd0, 8'd0);
    do_reset();
    cyc(3);
    check("jmp_ff_pc", 32'(pc_out), 32'hFF);
    rom[0] = enc(HLT, 3'd0, 3'd0, 8'd0);
    cyc(3);
    check("wrap_pc", 32'(pc_out), 32'h0);
    cyc(3);
    check("halt_state", 32'({halted, pc_out}), 32'h101);
    stuck = 0;
    for (int k = 0; k < 20; k++) begin
      if (halted !== 1'b1 || pc_out !== 8'h01 || imem_addr !== 8'h00 || out_valid !== 1'b0)
        stuck++;
      cyc(1);
    end
    check("halt_frozen", 32'(stuck), 32'd0);

    // 16-bit instance: signed overflow on ADDI
    clear_rom();
    rom2[0] = enc16(LDI,  4'd15, 4'd0, 16'h7FFF);
    rom2[1] = enc16(ADDI, 4'd15, 4'd0, 16'h0001);
    rom2[2] = enc16(OUT,  4'd15, 4'd0, 16'h0000);
    rom2[3] = enc16(HLT,  4'd0,  4'd0, 16'h0000);
    do_reset();
    cyc(6);
    check("w16_flags", 32'(flags2), 32'b1100);
    cyc(3);
    check("w16_out", 32'({out_valid2, out_data2}), 32'h18000);
    cyc(4);
    check("w16_halted", 32'(halted2), 32'h1);

    check("never_halted_and_valid", 32'(both_hi), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
